// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, the data-memory arbiter and the data memory.
// The arbiter connects through the slave modport; requesters and memory use the master modport.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [1:0]  p0_size;
  logic        p0_sign;
  logic        p0_done;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [1:0]  p1_size;
  logic        p1_sign;
  logic        p1_done;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic [31:0] address;
  logic [31:0] write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemDataSize;
  logic        MemDataSign;
  logic [31:0] read_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size, p0_sign,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_sign,
    input  read_data,
    output p0_done, p0_err, p0_rdata,
    output p1_done, p1_err, p1_rdata,
    output address, write_data, MemRead, MemWrite, MemDataSize, MemDataSign
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size, p0_sign,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_sign,
    output read_data,
    input  p0_done, p0_err, p0_rdata,
    input  p1_done, p1_err, p1_rdata,
    input  address, write_data, MemRead, MemWrite, MemDataSize, MemDataSign
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared big-endian data memory (CPU port 0, DMA/debug port 1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int MEM_BYTES     = 4096
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic             busy,
  output logic             gnt_id,
  output logic [1:0]       state_dbg
);
  // Handshake: a requester raises req with stable fields and holds it until its done
  // pulse (err qualified by done); it drops req the cycle after done. Any req still
  // high when the FSM is back in IDLE is taken as a new request.
  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  ACCESS    = 2'd1;
  localparam logic [1:0]  DONE      = 2'd2;
  localparam logic [3:0]  CNT_LOAD  = 4'(ACCESS_CYCLES - 1);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic        lat_sign;
  logic        lat_err;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_size;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  logic        any_req;
  logic        win;
  logic        win_we;
  logic        win_sign;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [1:0]  win_size;
  logic        win_illegal;
  logic [32:0] last_byte;
  logic [31:0] load_val;
  logic        in_access;
  logic        in_done;

  assign any_req = bus.p0_req | bus.p1_req;

`ifdef DMEM_ARB_RR_EN
  // rr_ptr names the port that wins a tie; it flips away from every granted port.
  logic rr_ptr;

  assign win = (bus.p0_req & bus.p1_req) ? rr_ptr : bus.p1_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= ~win;
    end
  end
`else
  assign win = ~bus.p0_req & bus.p1_req;
`endif

  always_comb begin
    win_we    = win ? bus.p1_we    : bus.p0_we;
    win_sign  = win ? bus.p1_sign  : bus.p0_sign;
    win_addr  = win ? bus.p1_addr  : bus.p0_addr;
    win_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    win_size  = win ? bus.p1_size  : bus.p0_size;
  end

  // 33-bit end address so accesses near 2^32 cannot wrap into range.
  always_comb begin
    last_byte   = {1'b0, win_addr};
    win_illegal = 1'b0;
    case (win_size)
      2'b11: begin
        last_byte   = {1'b0, win_addr} + 33'd3;
        win_illegal = (win_addr[1:0] != 2'b00);
      end
      2'b10: begin
        last_byte   = {1'b0, win_addr} + 33'd1;
        win_illegal = win_addr[0];
      end
      2'b01:   win_illegal = 1'b0;
      default: win_illegal = 1'b1;
    endcase
    if (last_byte >= MEM_LIMIT) win_illegal = 1'b1;
  end

  // Re-extending the low lanes is harmless if the memory already sized the data.
  always_comb begin
    case (lat_size)
      2'b01:   load_val = {{24{lat_sign & bus.read_data[7]}}, bus.read_data[7:0]};
      2'b10:   load_val = {{16{lat_sign & bus.read_data[15]}}, bus.read_data[15:0]};
      default: load_val = bus.read_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_sign  <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_size  <= 2'b00;
      gnt_id    <= 1'b0;
      rdata0    <= 32'd0;
      rdata1    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id    <= win;
            lat_we    <= win_we;
            lat_sign  <= win_sign;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            lat_size  <= win_size;
            lat_err   <= win_illegal;
            if (win_illegal) begin
              state <= DONE;
            end else begin
              state <= ACCESS;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_we) begin
              if (gnt_id) rdata1 <= load_val;
              else        rdata0 <= load_val;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);

  assign bus.address     = in_access ? lat_addr  : 32'd0;
  assign bus.write_data  = in_access ? lat_wdata : 32'd0;
  assign bus.MemDataSize = in_access ? lat_size  : 2'b00;
  assign bus.MemDataSign = in_access & lat_sign;
  assign bus.MemRead     = in_access & ~lat_we;
  assign bus.MemWrite    = in_access & lat_we;

  assign bus.p0_done  = in_done & ~gnt_id;
  assign bus.p1_done  = in_done & gnt_id;
  assign bus.p0_err   = in_done & ~gnt_id & lat_err;
  assign bus.p1_err   = in_done & gnt_id & lat_err;
  assign bus.p0_rdata = rdata0;
  assign bus.p1_rdata = rdata1;

  assign busy      = (state != IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array big-endian memory model.
// Grant-order expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;
  localparam int AC = 3;

  logic        clk;
  logic        reset;
  logic        busy;
  logic        gnt_id;
  logic [1:0]  state_dbg;
  logic [7:0]  mem [0:4095];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd [2];
  int          n_checks;
  int          n_pass;
  int          exp_order [4];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ACCESS_CYCLES(AC), .MEM_BYTES(4096)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  always @(negedge clk) begin
    if (bus.MemWrite) begin
      case (bus.MemDataSize)
        2'b11: begin
          mem[bus.address[11:0]]         <= bus.write_data[31:24];
          mem[bus.address[11:0] + 12'd1] <= bus.write_data[23:16];
          mem[bus.address[11:0] + 12'd2] <= bus.write_data[15:8];
          mem[bus.address[11:0] + 12'd3] <= bus.write_data[7:0];
        end
        2'b10: begin
          mem[bus.address[11:0]]         <= bus.write_data[15:8];
          mem[bus.address[11:0] + 12'd1] <= bus.write_data[7:0];
        end
        2'b01:   mem[bus.address[11:0]] <= bus.write_data[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.read_data = 32'd0;
    if (bus.MemRead) begin
      case (bus.MemDataSize)
        2'b11: bus.read_data = {mem[bus.address[11:0]], mem[bus.address[11:0] + 12'd1],
                                mem[bus.address[11:0] + 12'd2], mem[bus.address[11:0] + 12'd3]};
        2'b10: bus.read_data = {16'd0, mem[bus.address[11:0]], mem[bus.address[11:0] + 12'd1]};
        2'b01: bus.read_data = {24'd0, mem[bus.address[11:0]]};
        default: bus.read_data = 32'd0;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_port(input bit port, input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input bit sign);
    if (!port) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr;
      bus.p0_wdata = wdata; bus.p0_size = size; bus.p0_sign = sign;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr;
      bus.p1_wdata = wdata; bus.p1_size = size; bus.p1_sign = sign;
    end
  endtask

  // One transaction on one port; latency counts the req cycle as cycle 1.
  task automatic do_access(input string tag, input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input bit sign,
                           input bit exp_err);
    int cyc;
    int acc;
    bit done_seen;
    @(posedge clk); #1;
    drive_port(port, 1'b1, we, addr, wdata, size, sign);
    cyc = 1;
    acc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.MemRead || bus.MemWrite) begin
        acc++;
        check({tag, " mem_ctl"},
              {27'd0, bus.MemWrite, bus.MemRead, bus.MemDataSize, bus.MemDataSign},
              {27'd0, we, ~we, size, sign});
        check({tag, " mem_addr"}, bus.address, addr);
        check({tag, " wr_data"}, bus.write_data, wdata);
      end
      check({tag, " other_done"}, 32'(port ? bus.p0_done : bus.p1_done), 32'd0);
      done_seen = port ? bus.p1_done : bus.p0_done;
    end
    check({tag, " latency"}, 32'(cyc), exp_err ? 32'd2 : 32'(AC + 2));
    check({tag, " access_cycles"}, 32'(acc), exp_err ? 32'd0 : 32'(AC));
    check({tag, " err"}, 32'(port ? bus.p1_err : bus.p0_err), 32'(exp_err));
    check({tag, " gnt_id"}, 32'(gnt_id), 32'(port));
    if (!we && !exp_err) last_rd[port] = exp_q.pop_front();
    check({tag, " rdata"}, port ? bus.p1_rdata : bus.p0_rdata, last_rd[port]);
    @(posedge clk); #1;
    drive_port(port, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    check({tag, " idle_after"}, {30'd0, busy, port ? bus.p1_done : bus.p0_done}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int g;
    int cyc;
    bit seen_p1_done;
    n_checks = 0;
    n_pass = 0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset ctl", {23'd0, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err, bus.MemRead,
                        bus.MemWrite, bus.MemDataSign, busy, gnt_id}, 32'd0);
    check("reset address", bus.address, 32'd0);
    check("reset p0_rdata", bus.p0_rdata, 32'd0);
    reset = 1'b0;

    // word store then word load on port 0
    do_access("t1 st w4", 1'b0, 1'b1, 32'd4, 32'h01234567, 2'b11, 1'b0, 1'b0);
    exp_q.push_back(32'h01234567);
    do_access("t1 ld w4", 1'b0, 1'b0, 32'd4, 32'h0, 2'b11, 1'b0, 1'b0);
    exp_q.push_back(32'h00000123);
    do_access("t1 ld h4s", 1'b0, 1'b0, 32'd4, 32'h0, 2'b10, 1'b1, 1'b0);

    // illegal requests: rdata keeps 0x123
    do_access("t3 w6", 1'b0, 1'b0, 32'd6, 32'h0, 2'b11, 1'b0, 1'b1);
    do_access("t3 h11", 1'b0, 1'b0, 32'd11, 32'h0, 2'b10, 1'b0, 1'b1);
    do_access("t3 sz0", 1'b0, 1'b1, 32'd0, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b1);

    // range edges
    do_access("t5 st w4092", 1'b0, 1'b1, 32'd4092, 32'hA5A55A5A, 2'b11, 1'b0, 1'b0);
    exp_q.push_back(32'hA5A55A5A);
    do_access("t5 ld w4092", 1'b0, 1'b0, 32'd4092, 32'h0, 2'b11, 1'b0, 1'b0);
    exp_q.push_back(32'hFFFFFFA5);
    do_access("t5 ld b4092s", 1'b0, 1'b0, 32'd4092, 32'h0, 2'b01, 1'b1, 1'b0);
    exp_q.push_back(32'h00005A5A);
    do_access("t5 ld h4094", 1'b0, 1'b0, 32'd4094, 32'h0, 2'b10, 1'b0, 1'b0);
    do_access("t5 w4096", 1'b0, 1'b0, 32'd4096, 32'h0, 2'b11, 1'b0, 1'b1);
    do_access("t5 h4095", 1'b0, 1'b0, 32'd4095, 32'h0, 2'b10, 1'b0, 1'b1);

    // port 1 byte traffic
    do_access("t2 st w12", 1'b1, 1'b1, 32'd12, 32'h00000000, 2'b11, 1'b0, 1'b0);
    do_access("t2 st b13", 1'b1, 1'b1, 32'd13, 32'hDEADBE80, 2'b01, 1'b0, 1'b0);
    exp_q.push_back(32'hFFFFFF80);
    do_access("t2 ld b13s", 1'b1, 1'b0, 32'd13, 32'h0, 2'b01, 1'b1, 1'b0);
    exp_q.push_back(32'h00000080);
    do_access("t2 ld b13u", 1'b1, 1'b0, 32'd13, 32'h0, 2'b01, 1'b0, 1'b0);

    // both ports request continuously for four grants
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 1'b0, 32'd4, 32'h0, 2'b11, 1'b0);
    drive_port(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 2'b11, 1'b0);
    g = 0;
    cyc = 0;
    while (g < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.p0_done || bus.p1_done) begin
        check($sformatf("t4 grant%0d", g), 32'(bus.p1_done), 32'(exp_order[g]));
        check($sformatf("t4 gnt_id%0d", g), 32'(gnt_id), 32'(exp_order[g]));
        if (bus.p1_done) check($sformatf("t4 p1_rdata%0d", g), bus.p1_rdata, 32'h00800000);
        else             check($sformatf("t4 p0_rdata%0d", g), bus.p0_rdata, 32'h01234567);
        if (bus.p1_done) last_rd[1] = 32'h00800000;
        g++;
      end
    end
    check("t4 grants", 32'(g), 32'd4);
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);

    // reset in the second ACCESS cycle of a port-1 load
    @(posedge clk); #1;
    drive_port(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 2'b11, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6 mid_access", {30'd0, busy, bus.MemRead}, 32'd3);
    reset = 1'b1;
    #1;
    check("t6 rst ctl", {23'd0, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err, bus.MemRead,
                         bus.MemWrite, bus.MemDataSign, busy, gnt_id}, 32'd0);
    check("t6 rst address", bus.address, 32'd0);
    check("t6 rst p1_rdata", bus.p1_rdata, 32'd0);
    check("t6 rst p0_rdata", bus.p0_rdata, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    seen_p1_done = 1'b0;
    drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      seen_p1_done = seen_p1_done | bus.p1_done;
    end
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen_p1_done = seen_p1_done | bus.p1_done;
    end
    check("t6 no p1_done", 32'(seen_p1_done), 32'd0);
    exp_q.push_back(32'h01234567);
    do_access("t6 ld w4", 1'b0, 1'b0, 32'd4, 32'h0, 2'b11, 1'b0, 1'b0);
    check("exp_q drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the shared byte-addressed big-endian data memory between two requesters: port 0 is the CPU load/store path and port 1 is the DMA/debug path.
- Each request is checked for legal size, alignment and range, then sequenced onto the memory control signals for a fixed number of cycles.
- Read data and a completion pulse return to the winning port.
- Sits between the pipeline MEM stage / DMA engine and the data memory.

Parameters:
- ACCESS_CYCLES, 3: cycles MemRead/MemWrite are held per access; covers the memory's 200-unit read delay and negedge write; legal range 1-15.
- MEM_BYTES, 4096: addressable bytes; any byte of the access at address >= MEM_BYTES is an error.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req / p1_req  in  1  request; hold high with fields stable until the matching doneN pulse
- p0_we / p1_we  in  1  1 = store, 0 = load
- p0_addr / p1_addr  in  32  byte address
- p0_wdata / p1_wdata  in  32  store data; low bytes used for half/byte
- p0_size / p1_size  in  2  11 = word, 10 = half, 01 = byte, 00 = illegal
- p0_sign / p1_sign  in  1  sign-extend load when 1
- p0_done / p1_done  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  valid with done; access rejected
- p0_rdata / p1_rdata  out  32  load result, held until the next done on that port
- address  out  32  to memory
- write_data  out  32  to memory
- MemRead  out  1  to memory
- MemWrite  out  1  to memory
- MemDataSize  out  2  to memory
- MemDataSign  out  1  to memory
- read_data  in  32  from memory
- busy  out  1  FSM not in IDLE
- gnt_id  out  1  port owning the current/last access

Behaviour:
- Reset values: all outputs 0; FSM goes to IDLE; round-robin pointer points to port 0.
- Reset mid-operation: abandons the access with no done pulse. A write already in flight may or may not have committed.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, pick the winner, latch its fields into internal regs and set gnt_id.
  - Validity check on the latched fields. The access is illegal if any of these holds: size = 00; word with addr[1:0] != 0; half with addr[0] != 0; addr + bytes - 1 >= MEM_BYTES.
  - Illegal access: go to DONE with err set; MemRead and MemWrite never assert.
  - Legal access: go to ACCESS and load counter = ACCESS_CYCLES - 1.
- ACCESS:
  - address, write_data, MemDataSize and MemDataSign are driven from the latched regs.
  - MemRead = ~we and MemWrite = we, held constant for exactly ACCESS_CYCLES cycles.
  - Counter decrements each cycle. At counter = 0, a load captures read_data into the winner's rdata reg; then go to DONE.
- DONE:
  - Pulse the winner's done for one cycle, with err valid.
  - MemRead and MemWrite are 0; address and control return to 0.
  - Next state is IDLE. The requester drops req on the cycle after done; a req still high in the following IDLE is a new request.
- Outside ACCESS, all memory outputs are 0.
- Latency: legal access gives done 2 + ACCESS_CYCLES cycles after req is sampled; illegal access gives done 2 cycles after.
- Stores: rdata is unchanged.
- Error response: rdata is unchanged, err = 1.
- Simultaneous requests in IDLE: resolved per the arbitration mode below. The loser waits with req held and no done pulse.
- A request arriving during ACCESS or DONE is not sampled until IDLE.
- Back-to-back throughput: one access per ACCESS_CYCLES + 2 cycles.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both request, the port not granted most recently wins; the pointer updates on every grant, including error grants.
- Undefined: fixed priority, port 0 always wins; a port-1 request waits until port 0 is idle. The round-robin pointer is not built.

Test Plan:
1. p0 word store addr 4, data 32'h01234567, then p0 word load addr 4, sign 0 -> MemWrite high for 3 cycles; load done with p0_rdata = 32'h01234567, err = 0; done 5 cycles after req.
2. p1 byte store 8'h80 at addr 13, then byte loads at addr 13 with sign 1 and sign 0 -> p1_rdata = 32'hFFFFFF80, then 32'h00000080.
3. Misaligned requests: p0 word at addr 6, p0 half at addr 11, size 00 -> each gives err = 1 with done 2 cycles after req; MemRead and MemWrite never assert; p0_rdata unchanged.
4. p0 and p1 requesting in the same cycle, repeated 4 times:
   - Without DMEM_ARB_RR_EN: grant order 0,0,0,0 while p0 keeps requesting.
   - With DMEM_ARB_RR_EN: order 0,1,0,1.
5. Range check: word access at addr 4092 is legal; word at 4096 and half at 4095 give err = 1.
6. Assert reset during the second ACCESS cycle of a p1 load -> all outputs 0 immediately; no p1_done; after release, a fresh p0 load completes normally.
